// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state encoding and accumulator sizing for serial MAC neurons
package neuron_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, ACT = 2'd2, DONE = 2'd3} state_e;
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_MAC  = MAC;
   localparam logic [1:0] ST_ACT  = ACT;
   localparam logic [1:0] ST_DONE = DONE;
   function automatic int acc_width(input int n, input int xw, input int ww);
      return ww + xw + $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/neuron_relu_sat.sv
// neuron_relu_sat: clamp a signed accumulator into an unsigned OUT_W range (ReLU plus saturation)
module neuron_relu_sat #(
   parameter int ACC_W = 12,
   parameter int OUT_W = 10
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic        [OUT_W-1:0] res
);
   localparam int EW = (ACC_W > OUT_W + 1) ? ACC_W : OUT_W + 2;
   localparam logic signed [EW-1:0] MAX = {{(EW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
   logic signed [EW-1:0] a;
   assign a = EW'(acc);
   // negative clamps to zero, anything above the output range pins to all ones
   always_comb res = a[EW-1] ? '0 : (a > MAX ? '1 : a[OUT_W-1:0]);
endmodule

// File: rtl/serial_mac_neuron.sv
// serial_mac_neuron: ReLU neuron with one shared multiplier, one product per cycle; NEURON_BIAS_EN adds bias_i
module serial_mac_neuron
   import neuron_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int X_W      = 1,
   parameter int W_W      = 8,
   parameter int OUT_W    = 10,
   parameter int ACC_W    = acc_width(N_INPUTS, X_W, W_W)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [N_INPUTS*X_W-1:0] x_i,
   input  logic [N_INPUTS*W_W-1:0] w_i,
`ifdef NEURON_BIAS_EN
   input  logic [W_W-1:0]          bias_i,
`endif
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [OUT_W-1:0]        neuron_o
);
   localparam int IDX_W = $clog2(N_INPUTS);
   localparam int PW    = W_W + X_W + 1;
   logic [1:0]                state;
   logic [IDX_W-1:0]          idx;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_init;
   logic [N_INPUTS*X_W-1:0]   x_q;
   logic [N_INPUTS*W_W-1:0]   w_q;
   logic signed [PW-1:0]      w_ext;
   logic signed [PW-1:0]      x_ext;
   logic signed [PW-1:0]      prod;
   logic [OUT_W-1:0]          res;
`ifdef NEURON_BIAS_EN
   assign acc_init = {{(ACC_W-W_W){bias_i[W_W-1]}}, bias_i};
`else
   assign acc_init = '0;
`endif
   // captured vectors shift down each MAC cycle so element 0 is always the current operand
   assign w_ext = {{(X_W+1){w_q[W_W-1]}}, w_q[W_W-1:0]};
   assign x_ext = {{W_W{1'b0}}, x_q[X_W-1:0]};
   assign prod  = w_ext * x_ext;
   assign in_ready_o  = rst_i && state == ST_IDLE;
   assign out_valid_o = state == ST_DONE;
   neuron_relu_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (.acc(acc), .res(res));
   // sequencer: capture, accumulate one product per cycle, clamp, hold result until taken
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= ST_IDLE;
         idx      <= '0;
         acc      <= '0;
         x_q      <= '0;
         w_q      <= '0;
         neuron_o <= '0;
      end else if (en_i) begin
         case (state)
            ST_IDLE: if (in_valid_i) begin
               x_q   <= x_i;
               w_q   <= w_i;
               acc   <= acc_init;
               idx   <= '0;
               state <= ST_MAC;
            end
            ST_MAC: begin
               acc   <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
               idx   <= idx + 1'b1;
               x_q   <= x_q >> X_W;
               w_q   <= w_q >> W_W;
               state <= idx == IDX_W'(N_INPUTS-1) ? ST_ACT : ST_MAC;
            end
            ST_ACT: begin
               neuron_o <= res;
               state    <= ST_DONE;
            end
            default: state <= out_ready_i ? ST_IDLE : ST_DONE;
         endcase
      end
   end
endmodule

// File: doc/serial_mac_neuron.md
Name: serial_mac_neuron

Overview:
- Parametrised successor to the 4-input binary-gated hidden neuron.
- Computes ReLU(sum of x[k]*w[k], plus an optional bias) over N_INPUTS multi-bit inputs and signed weights.
- Uses a single time-multiplexed multiplier, one product per cycle, with valid/ready handshakes on both sides.
- Sits between the input/weight register bank and the output-layer neurons.

Parameters:
- N_INPUTS, 4, number of inputs/weights; must be >= 2.
- X_W, 1, input activation width, unsigned (1 = binary gating, as in the previous generation).
- W_W, 8, weight width, signed two's complement, Q1.(W_W-1).
- OUT_W, 10, output width, unsigned, same fractional alignment as the weights.
- ACC_W, W_W+X_W+$clog2(N_INPUTS)+1, accumulator width, signed; must never overflow.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- en_i  in  1  global stall; when low, all state and registers hold
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  block can accept a vector
- x_i  in  N_INPUTS*X_W  packed inputs, element k at [k*X_W +: X_W]
- w_i  in  N_INPUTS*W_W  packed weights, element k at [k*W_W +: W_W]
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- neuron_o  out  OUT_W  ReLU/saturated result
- bias_i  in  W_W  signed bias; port exists only with NEURON_BIAS_EN

Behaviour:
- Reset is checked on the clk_i edge while rst_i=0:
  - state goes to IDLE; accumulator, index and captured vectors clear.
  - neuron_o=0, out_valid_o=0, in_ready_o=0 during reset, then 1 in IDLE.
- Reset asserted mid-operation aborts the computation. No output is produced.
- FSM states are IDLE, MAC, ACT, DONE. Transitions occur only on cycles with en_i=1.
- IDLE:
  - in_ready_o=1.
  - When in_valid_i && in_ready_o && en_i: capture x_i and w_i into internal registers, clear the accumulator (or load the sign-extended bias), set idx=0, go to MAC.
- MAC:
  - Each cycle: acc += sext(w[idx]) * zext(x[idx]); idx++.
  - After the idx=N_INPUTS-1 update, go to ACT.
  - Inputs changing after capture have no effect.
- ACT:
  - If acc < 0: result = 0.
  - Else if acc > 2^OUT_W-1: result = 2^OUT_W-1.
  - Else: result = acc[OUT_W-1:0].
  - Register result into neuron_o and go to DONE.
- DONE:
  - out_valid_o=1; neuron_o is held stable.
  - When out_ready_i && en_i: go to IDLE.
  - out_valid_o is low in all other states. neuron_o keeps its last value until the next ACT.
- Latency: acceptance at cycle T gives out_valid_o=1 at T+N_INPUTS+2 when en_i stays high.
- Throughput: one vector per N_INPUTS+3 cycles with out_ready_i tied high.
- Backpressure: in_ready_o stays 0 from acceptance until the cycle after the DONE handshake. No new vector is accepted in DONE, even when out_ready_i=1.
- en_i=0 in any state freezes everything; the handshake is not honoured that cycle.
- x=0 or all weights 0 gives result 0.

Optional Feature:
- Macro NEURON_BIAS_EN.
- Defined: bias_i port is present. It is captured in the IDLE acceptance cycle by loading the accumulator with sext(bias_i) instead of 0. Latency is unchanged.
- Undefined: no bias_i port; the accumulator starts at 0.

Decomposition:
- Package neuron_pkg:
  - state enum (IDLE, MAC, ACT, DONE);
  - function acc_width(n, xw, ww);
  - localparam constants for the state encoding.
- Sub-module neuron_relu_sat: combinational ACC_W signed to OUT_W unsigned clamp, parametrised by ACC_W and OUT_W. It is reused later by the output-layer neuron.

Test Plan:
- Defaults, w={0x08,0x10,0x20,0x40} (w3..w0), x=4'b1111, in_valid_i 1 cycle, out_ready_i=1 -> out_valid_o at T+6, neuron_o=120 for 1 cycle, in_ready_o=1 at T+7.
- w0=0x80 (-128), w1..w3=0x10, x=4'b1111 -> acc=-80 -> neuron_o=0.
- OUT_W=8 override, all w=0x7F, x=4'b1111 -> acc=508 -> neuron_o=255 (saturated).
- Backpressure: out_ready_i=0 for 5 cycles after out_valid_o -> neuron_o and out_valid_o stable, in_ready_o=0, in_valid_i pulses ignored. Release -> IDLE next cycle.
- Stall/reset: en_i=0 for 3 cycles during MAC -> out_valid_o delayed exactly 3 cycles, same value. rst_i=0 at idx=2 -> next cycle out_valid_o=0, in_ready_o=0 while in reset, in_ready_o=1 the cycle after release, no result emitted.
- NEURON_BIAS_EN, X_W=4, bias=0xF0 (-16), w all 0x10, x={1,2,3,4} -> acc=144 -> neuron_o=144.
